// File: rtl/cu_sched.sv
// cu_sched: walks the feature map band by band for the 3x3 conv engine and collects window sums.
// Issue->FIFO write 2 cycles (res_valid at issue+3); result issues wait for FIFO credit, then replay 2 columns.
module cu_sched #(
    parameter int IMG_W     = 32,
    parameter int IMG_H     = 32,
    parameter int ADDR_W    = 16,
    parameter int IDX_W     = 8,
    parameter int RES_DEPTH = 4
) (
    input  logic              clk,
    input  logic              nrst,
    input  logic              start,
    output logic              busy,
    output logic              done,
    output logic              buf_ren,
    output logic [ADDR_W-1:0] buf_raddr,
    output logic [8:0]        pe_en_ctrl,
    input  logic [15:0]       pe_out,
    output logic              res_valid,
    input  logic              res_ready,
    output logic [15:0]       res_data,
    output logic [IDX_W-1:0]  res_row,
    output logic [IDX_W-1:0]  res_col
);
    localparam int PTR_W = (RES_DEPTH > 1) ? $clog2(RES_DEPTH) : 1;
    localparam int CNT_W = $clog2(RES_DEPTH + 1) + 1;
    localparam logic [IDX_W-1:0] LAST_COL  = IDX_W'(IMG_W - 1);
    localparam logic [IDX_W-1:0] LAST_BAND = IDX_W'(IMG_H - 3);
    localparam logic [PTR_W-1:0] LAST_PTR  = PTR_W'(RES_DEPTH - 1);
    localparam logic [CNT_W-1:0] DEPTH_C   = CNT_W'(RES_DEPTH);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_STALL, S_DRAIN} state_t;

    typedef struct packed {
        logic             vld;
        logic [IDX_W-1:0] row;
        logic [IDX_W-1:0] col;
    } tag_t;

    typedef struct packed {
        logic [15:0]      dat;
        logic [IDX_W-1:0] row;
        logic [IDX_W-1:0] col;
    } res_t;

    state_t           state_q, state_d;
    logic [IDX_W-1:0] band_q, band_d;
    logic [IDX_W-1:0] col_q, col_d;
    logic [1:0]       fill_q, fill_d;
    logic             pe_en_q, pe_en_d;
    logic             done_q, done_d;
    tag_t             t1_q, t1_d, t2_q, t2_d;
    res_t             fifo_q [RES_DEPTH];
    res_t             fifo_d [RES_DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic [CNT_W-1:0] inflight;
    logic             is_res, credit_ok, issue, push, pop;

    // Credit counts every result already issued but not yet in the FIFO, so a full FIFO never sees a push.
    always_comb begin
        inflight  = CNT_W'(t1_q.vld) + CNT_W'(t2_q.vld);
        is_res    = (fill_q == 2'd2);
        credit_ok = (cnt_q + inflight) < DEPTH_C;
        issue     = (state_q == S_RUN) && (!is_res || credit_ok);
        push      = t2_q.vld;
        pop       = res_valid && res_ready;
    end

    always_comb begin
        state_d  = state_q;
        band_d   = band_q;
        col_d    = col_q;
        fill_d   = fill_q;
        done_d   = 1'b0;
        pe_en_d  = issue;
        t1_d.vld = issue && is_res;
        t1_d.row = band_q;
        t1_d.col = col_q - IDX_W'(2);
        t2_d     = t1_q;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    band_d  = '0;
                    col_d   = '0;
                    fill_d  = '0;
                    state_d = S_RUN;
                end
            end
            S_RUN: begin
                if (issue) begin
                    fill_d = is_res ? 2'd2 : fill_q + 2'd1;
                    if (col_q == LAST_COL) begin
                        col_d  = '0;
                        fill_d = '0;
                        if (band_q == LAST_BAND) begin
                            state_d = S_DRAIN;
                        end else begin
                            band_d = band_q + IDX_W'(1);
                        end
                    end else begin
                        col_d = col_q + IDX_W'(1);
                    end
                end else begin
                    state_d = S_STALL;
                end
            end
            S_STALL: begin
                // The engine delay line kept shifting; re-prime it with the two columns left of the window.
                if (credit_ok) begin
                    col_d   = col_q - IDX_W'(2);
                    fill_d  = '0;
                    state_d = S_RUN;
                end
            end
            S_DRAIN: begin
                // Once the last result tag is in the capture stage, its FIFO write happens this cycle.
                if (!t1_q.vld) begin
                    state_d = S_IDLE;
                    done_d  = 1'b1;
                    band_d  = '0;
                    col_d   = '0;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        fifo_d   = fifo_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        cnt_d    = cnt_q;
        if (push) begin
            fifo_d[wr_ptr_q].dat = pe_out;
            fifo_d[wr_ptr_q].row = t2_q.row;
            fifo_d[wr_ptr_q].col = t2_q.col;
            wr_ptr_d = (wr_ptr_q == LAST_PTR) ? '0 : wr_ptr_q + PTR_W'(1);
        end
        if (pop) begin
            rd_ptr_d = (rd_ptr_q == LAST_PTR) ? '0 : rd_ptr_q + PTR_W'(1);
        end
        case ({push, pop})
            2'b10:   cnt_d = cnt_q + CNT_W'(1);
            2'b01:   cnt_d = cnt_q - CNT_W'(1);
            default: cnt_d = cnt_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!nrst) begin
            state_q  <= S_IDLE;
            band_q   <= '0;
            col_q    <= '0;
            fill_q   <= '0;
            pe_en_q  <= 1'b0;
            done_q   <= 1'b0;
            t1_q     <= '0;
            t2_q     <= '0;
            fifo_q   <= '{default: '0};
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            state_q  <= state_d;
            band_q   <= band_d;
            col_q    <= col_d;
            fill_q   <= fill_d;
            pe_en_q  <= pe_en_d;
            done_q   <= done_d;
            t1_q     <= t1_d;
            t2_q     <= t2_d;
            fifo_q   <= fifo_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
        end
    end

    assign busy       = (state_q != S_IDLE);
    assign done       = done_q;
    assign buf_ren    = issue;
    assign buf_raddr  = ADDR_W'(band_q) * ADDR_W'(IMG_W) + ADDR_W'(col_q);
    assign pe_en_ctrl = {9{pe_en_q}};
    assign res_valid  = (cnt_q != '0);
    assign res_data   = fifo_q[rd_ptr_q].dat;
    assign res_row    = fifo_q[rd_ptr_q].row;
    assign res_col    = fifo_q[rd_ptr_q].col;

    assert property (@(posedge clk) disable iff (!nrst) !(push && !pop && cnt_q == DEPTH_C));

endmodule

// File: tb/tb_cu_sched.sv
// Bench for cu_sched: a 5x4 all-ones instance and an 8x4 ramp instance, each fed by a shifting engine model.
module tb_cu_sched;
    localparam logic [15:0] POISON = 16'd500;

    logic clk = 1'b0;
    logic nrst;
    always #5 clk = ~clk;

    logic        a_start, a_busy, a_done, a_ren, a_vld, a_rdy;
    logic [15:0] a_raddr, a_pe_out, a_dat;
    logic [8:0]  a_pe;
    logic [7:0]  a_row, a_col;

    logic        b_start, b_busy, b_done, b_ren, b_vld, b_rdy;
    logic [15:0] b_raddr, b_pe_out, b_dat;
    logic [8:0]  b_pe;
    logic [7:0]  b_row, b_col;

    cu_sched #(.IMG_W(5), .IMG_H(4), .ADDR_W(16), .IDX_W(8), .RES_DEPTH(4)) u_a (
        .clk(clk), .nrst(nrst), .start(a_start), .busy(a_busy), .done(a_done),
        .buf_ren(a_ren), .buf_raddr(a_raddr), .pe_en_ctrl(a_pe), .pe_out(a_pe_out),
        .res_valid(a_vld), .res_ready(a_rdy), .res_data(a_dat), .res_row(a_row), .res_col(a_col)
    );

    cu_sched #(.IMG_W(8), .IMG_H(4), .ADDR_W(16), .IDX_W(8), .RES_DEPTH(4)) u_b (
        .clk(clk), .nrst(nrst), .start(b_start), .busy(b_busy), .done(b_done),
        .buf_ren(b_ren), .buf_raddr(b_raddr), .pe_en_ctrl(b_pe), .pe_out(b_pe_out),
        .res_valid(b_vld), .res_ready(b_rdy), .res_data(b_dat), .res_row(b_row), .res_col(b_col)
    );

    function automatic int pix(input int r, input int c);
        return r * 8 + c;
    endfunction

    function automatic logic [15:0] col_word(input logic [15:0] addr);
        int band, c, s;
        band = int'(addr) / 8;
        c    = int'(addr) % 8;
        s    = 0;
        for (int r = 0; r < 3; r++) s += pix(band + r, c);
        return 16'(s);
    endfunction

    function automatic logic [15:0] golden(input int band, input int c);
        int s;
        s = 0;
        for (int r = 0; r < 3; r++)
            for (int j = 0; j < 3; j++) s += pix(band + r, c + j);
        return 16'(s);
    endfunction

    // Engine models: 1-cycle buffer read, then a delay line that shifts every cycle; unread slots carry POISON.
    logic [15:0] a_rd, a_dl0, a_dl1, a_dl2;
    logic [15:0] b_rd, b_dl0, b_dl1, b_dl2;
    always @(posedge clk) begin
        a_rd  <= a_ren ? 16'd3 : POISON;
        a_dl0 <= a_rd;
        a_dl1 <= a_dl0;
        a_dl2 <= a_dl1;
        b_rd  <= b_ren ? col_word(b_raddr) : POISON;
        b_dl0 <= b_rd;
        b_dl1 <= b_dl0;
        b_dl2 <= b_dl1;
    end
    assign a_pe_out = a_dl0 + a_dl1 + a_dl2;
    assign b_pe_out = b_dl0 + b_dl1 + b_dl2;

    logic [31:0] a_q[$];
    logic [31:0] b_q[$];
    always @(negedge clk) begin
        if (a_vld && a_rdy) a_q.push_back({a_dat, a_row, a_col});
        if (b_vld && b_rdy) b_q.push_back({b_dat, b_row, b_col});
    end

    logic [63:0] a_outs, b_outs;
    assign a_outs = {3'b0, a_busy, a_done, a_ren, a_raddr, a_pe, a_vld, a_dat, a_row, a_col};
    assign b_outs = {3'b0, b_busy, b_done, b_ren, b_raddr, b_pe, b_vld, b_dat, b_row, b_col};

    int n_chk  = 0;
    int n_fail = 0;

    task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    initial begin
        logic        exp_ren, exp_pe, exp_vld, got_done;
        logic [31:0] got_ent, exp_ent;
        int          kk, exp_addr;

        nrst = 1'b0; a_start = 1'b0; b_start = 1'b0; a_rdy = 1'b0; b_rdy = 1'b0;

        // Reset held 3 cycles with random inputs.
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check_eq("rst_a_outs", a_outs, 64'd0);
            check_eq("rst_b_outs", b_outs, 64'd0);
            a_start = 1'($urandom_range(0, 1));
            b_start = 1'($urandom_range(0, 1));
            a_rdy   = 1'($urandom_range(0, 1));
            b_rdy   = 1'($urandom_range(0, 1));
        end
        nrst = 1'b1; a_start = 1'b0; b_start = 1'b0; a_rdy = 1'b0; b_rdy = 1'b0;
        @(negedge clk);
        check_eq("post_rst_a_outs", a_outs, 64'd0);
        check_eq("post_rst_b_outs", b_outs, 64'd0);

        // 5x4 all-ones, res_ready=1; start while busy at cycle 4 (ignored), start on the done cycle 13.
        a_q.delete();
        a_rdy = 1'b1;
        @(negedge clk);
        a_start = 1'b1;
        for (int k = 1; k <= 27; k++) begin
            @(negedge clk);
            kk      = (k >= 14) ? k - 13 : k;
            exp_ren = (kk >= 1 && kk <= 10);
            exp_pe  = (kk >= 2 && kk <= 11);
            exp_vld = (kk >= 6 && kk <= 8) || (kk >= 11 && kk <= 13);
            check_eq("a_buf_ren", 64'(a_ren), 64'(exp_ren));
            if (exp_ren) check_eq("a_buf_raddr", 64'(a_raddr), 64'(kk - 1));
            check_eq("a_pe_en", 64'(a_pe), exp_pe ? 64'h1FF : 64'h0);
            check_eq("a_res_valid", 64'(a_vld), 64'(exp_vld));
            check_eq("a_busy", 64'(a_busy), 64'(kk >= 1 && kk <= 12));
            check_eq("a_done", 64'(a_done), 64'(kk == 13));
            a_start = (k == 4 || k == 13);
        end
        a_start = 1'b0;
        @(negedge clk);
        check_eq("a_res_count", 64'(a_q.size()), 64'd12);
        for (int i = 0; i < 12; i++) begin
            got_ent = (i < a_q.size()) ? a_q[i] : 32'hFFFF_FFFF;
            exp_ent = {16'd9, 8'((i % 6) / 3), 8'(i % 3)};
            check_eq("a_result", 64'(got_ent), 64'(exp_ent));
        end

        // 8x4 ramp with back-pressure: res_ready low until cycle 20.
        b_q.delete();
        b_rdy = 1'b0;
        @(negedge clk);
        b_start = 1'b1;
        for (int k = 1; k <= 38; k++) begin
            @(negedge clk);
            b_start  = 1'b0;
            exp_ren  = (k >= 1 && k <= 6) || (k >= 22 && k <= 33);
            exp_addr = (k <= 6) ? k - 1 : k - 18;
            exp_pe   = (k >= 2 && k <= 7) || (k >= 23 && k <= 34);
            exp_vld  = (k >= 6 && k <= 23) || k == 27 || k == 28 || (k >= 31 && k <= 36);
            check_eq("b_buf_ren", 64'(b_ren), 64'(exp_ren));
            if (exp_ren) check_eq("b_buf_raddr", 64'(b_raddr), 64'(exp_addr));
            check_eq("b_pe_en", 64'(b_pe), exp_pe ? 64'h1FF : 64'h0);
            check_eq("b_res_valid", 64'(b_vld), 64'(exp_vld));
            check_eq("b_busy", 64'(b_busy), 64'(k >= 1 && k <= 35));
            check_eq("b_done", 64'(b_done), 64'(k == 36));
            if (k == 20) b_rdy = 1'b1;
        end
        check_eq("b_res_count", 64'(b_q.size()), 64'd12);
        check_eq("b_first_window", 64'((b_q.size() > 0) ? b_q[0] : 32'hFFFF_FFFF), 64'({16'd81, 8'd0, 8'd0}));
        for (int i = 0; i < 12; i++) begin
            got_ent = (i < b_q.size()) ? b_q[i] : 32'hFFFF_FFFF;
            exp_ent = {golden(i / 6, i % 6), 8'(i / 6), 8'(i % 6)};
            check_eq("b_result", 64'(got_ent), 64'(exp_ent));
        end

        // Reset in cycle 5 of a pass, then a clean rerun.
        b_q.delete();
        b_rdy = 1'b1;
        @(negedge clk);
        b_start = 1'b1;
        for (int k = 1; k <= 5; k++) begin
            @(negedge clk);
            b_start = 1'b0;
        end
        nrst = 1'b0;
        @(negedge clk);
        check_eq("midrst_busy", 64'(b_busy), 64'd0);
        check_eq("midrst_res_valid", 64'(b_vld), 64'd0);
        check_eq("midrst_buf_ren", 64'(b_ren), 64'd0);
        nrst = 1'b1;
        @(negedge clk);
        check_eq("midrst_idle_outs", b_outs, 64'd0);
        b_start = 1'b1;
        got_done = 1'b0;
        for (int k = 1; k <= 100 && !got_done; k++) begin
            @(negedge clk);
            b_start = 1'b0;
            if (b_done) got_done = 1'b1;
        end
        check_eq("midrst_done_seen", 64'(got_done), 64'd1);
        repeat (3) @(negedge clk);
        check_eq("midrst_res_count", 64'(b_q.size()), 64'd12);
        for (int i = 0; i < 12; i++) begin
            got_ent = (i < b_q.size()) ? b_q[i] : 32'hFFFF_FFFF;
            exp_ent = {golden(i / 6, i % 6), 8'(i / 6), 8'(i % 6)};
            check_eq("midrst_result", 64'(got_ent), 64'(exp_ent));
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/cu_sched.md
# cu_sched

Sequencer and result collector for the 3x3 streaming convolution engine. It walks a feature map stored as 3-row column words, one 3-row band at a time, and issues one column read per cycle to the line buffer. It drives the engine's PE enables and tags each valid 3x3 window. Completed 16-bit window sums are captured into a small result FIFO with valid/ready back-pressure, and the block replays columns to rebuild the engine's un-stallable delay line after a stall.

## Interface
- IMG_W, 32: image width in columns (>= 3)
- IMG_H, 32: image height in rows (>= 3); bands = IMG_H-2
- ADDR_W, 16: line-buffer address width
- IDX_W, 8: width of result row/column tags
- RES_DEPTH, 4: result FIFO depth (>= 3)

Ports:
- clk  in  1  clock
- nrst  in  1  reset, synchronous, active-low
- start  in  1  begin a full-image pass; ignored while busy
- busy  out  1  pass in progress
- done  out  1  one-cycle pulse when the last result is written to the FIFO
- buf_ren  out  1  line-buffer read strobe; fixed 1-cycle read latency
- buf_raddr  out  ADDR_W  band*IMG_W + col
- pe_en_ctrl  out  9  engine PE enables
- pe_out  in  16  engine window sum
- res_valid  out  1  FIFO head valid
- res_ready  in  1  downstream accepts the head
- res_data  out  16  window sum
- res_row  out  IDX_W  band index (window top row)
- res_col  out  IDX_W  window left column

## Operation
- FSM states: IDLE, RUN, STALL, DRAIN.
- IDLE: when start=1, clear band/col/fill and go to RUN.
- RUN, one column issued per cycle (buf_ren=1, buf_raddr=band*IMG_W+col):
  - fill counts consecutive contiguous issues in the current band (0..2, saturating). An issue with fill==2 is a result issue for window col-2..col.
  - A result issue requires fifo_count + inflight < RES_DEPTH. fifo_count is the value before this cycle's pop; inflight is the number of result issues in the 2-cycle pipe. If the check fails, go to STALL with no issue. Non-result issues are always allowed.
  - After col IMG_W-1: col <= 0, band++, fill <= 0. After the last column of band IMG_H-3, go to DRAIN.
- STALL: buf_ren=0. The engine delay line keeps shifting, so the window is lost. When credit becomes available: col <= col-2, fill <= 0, return to RUN. This replays 2 priming columns.
- DRAIN: wait until inflight==0, then pulse done, go to IDLE, and set busy=0.
- pe_en_ctrl = 9'h1FF in the cycle after any issue (aligned with data on the engine input), else 9'h000.
- A 2-deep tag pipe carries {is_result, band, col-2}. At issue+2, if is_result, push {pe_out, band, col-2} into the FIFO.
- FIFO: pop when res_valid && res_ready. Simultaneous push and pop leaves the count unchanged. Overflow cannot occur by construction; assert it in simulation.
- Results emerge in raster order: band-major, column ascending, with no duplicates or gaps, including across replays.
- Reset mid-pass: everything returns to reset values, the FIFO is emptied, and in-flight tags are discarded.

## Timing
- Reset values: busy=0, done=0, buf_ren=0, buf_raddr=0, pe_en_ctrl=0, res_valid=0, res_data=0, res_row=0, res_col=0.
- start sampled at edge of cycle 0 leads to the first issue (col 0, band 0) in cycle 1, with busy=1 from cycle 1.
- Issue at cycle t:
  - buf data and pe_en_ctrl=1FF arrive at the engine in t+1.
  - pe_out is valid in t+2 and is captured at the end of t+2.
  - res_valid is visible at t+3.
- With no stalls, a pass takes exactly (IMG_H-2)*IMG_W contiguous issue cycles.
- done pulses in the cycle after the final FIFO write; busy falls in that same cycle.
- Minimum stall penalty: 2 replay issue cycles per stall episode.

## Test plan
- Reset: hold nrst=0 for 3 cycles with random inputs. All outputs are 0 during and after reset; the FIFO is empty.
- IMG_W=5, IMG_H=4, res_ready=1, start at cycle 0:
  - buf_ren is high for cycles 1-10; addresses run 0..9.
  - First res_valid at cycle 6.
  - 6 results tagged (0,0),(0,1),(0,2),(1,0),(1,1),(1,2).
  - done pulses once.
- All-ones pixels with a unity filter: every res_data = 9. A pixel ramp matches the golden 3x3 convolution per tag.
- Back-pressure, IMG_W=8, res_ready=0 from start:
  - Issues stop when fifo_count+inflight reaches 4.
  - Raise res_ready after 20 cycles. buf_raddr replays col-2 and col-1 before resuming.
  - Output sequence is complete and in order with no duplicates.
- start pulsed while busy is ignored and the address sequence is unchanged. start asserted on the done cycle launches a new pass.
- nrst low in cycle 5 of a pass: busy=0 and res_valid=0 next cycle. A subsequent start produces a full clean result set.
